// File: rtl/ppb_io_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ppb_io_bridge_if
// Description : Programming-write handshake between the PPB I/O bridge and
//               the memory loader. The bridge raises prog_valid with a stable
//               address/data pair; the loader answers with prog_ready.
// Ports       : prog_valid         - write pending (bridge -> loader)
//               prog_ready         - loader accepts this cycle (loader -> bridge)
//               ProgrammingAddress - captured address, ADDR_W bits
//               ProgrammingData    - captured data, DATA_W bits
// Revision    : 1.0 - initial release
// ============================================================================
interface ppb_io_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              prog_valid;
    logic              prog_ready;
    logic [ADDR_W-1:0] ProgrammingAddress;
    logic [DATA_W-1:0] ProgrammingData;

    modport master (
        output prog_valid,
        output ProgrammingAddress,
        output ProgrammingData,
        input  prog_ready
    );

    modport slave (
        input  prog_valid,
        input  ProgrammingAddress,
        input  ProgrammingData,
        output prog_ready
    );
endinterface
`default_nettype wire

// File: rtl/ppb_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ppb_io_bridge
// Description : Front-panel bridge between the PPB device I/O vectors and the
//               CPU core. Synchronises the raw switches/buttons, debounces
//               the step/reset/write buttons, produces a one-cycle clock-step
//               pulse, runs a valid/ready programming-write handshake toward
//               the memory loader and drives a freezable snapshot of the
//               debug vector back to the panel.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               device_inputs      - raw panel inputs (asynchronous)
//               device_outputs     - registered debug image to the panel
//               dbg_vector         - live CPU debug signals
//               clk_auto_en        - synchronised free-run enable
//               clk_step           - one-cycle step pulse
//               cpu_reset          - debounced reset-button level
//               programming_en     - synchronised programming-mode switch
//               prog               - programming-write handshake (master)
//               prog_drop          - sticky lost-write flag
// Revision    : 1.0 - initial release
// ============================================================================
module ppb_io_bridge #(
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 8,
    parameter int N_IN            = 60,
    parameter int N_OUT           = 120,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [N_IN-1:0]  device_inputs,
    output logic      [N_OUT-1:0] device_outputs,
    input  wire logic [N_OUT-1:0] dbg_vector,
    output logic                  clk_auto_en,
    output logic                  clk_step,
    output logic                  cpu_reset,
    output logic                  programming_en,
    ppb_io_bridge_if.master       prog,
    output logic                  prog_drop
);

    // Panel input bit map
    localparam int c_BIT_AUTO   = 0;
    localparam int c_BIT_STEP   = 1;
    localparam int c_BIT_RST    = 2;
    localparam int c_BIT_ADDR   = 3;
    localparam int c_BIT_DATA   = 3 + ADDR_W;
    localparam int c_BIT_PEN    = 3 + ADDR_W + DATA_W;
    localparam int c_BIT_WRITE  = c_BIT_PEN + 1;
    localparam int c_BIT_FREEZE = c_BIT_PEN + 2;
    localparam int c_N_USED     = c_BIT_PEN + 3;

    // Debounced button indices
    localparam int c_BTN_STEP  = 0;
    localparam int c_BTN_RST   = 1;
    localparam int c_BTN_WRITE = 2;

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the cycle that completes the stable window
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser chains (only the bits that are actually used)
    // ------------------------------------------------------------------
    logic [c_N_USED-1:0] r_sync [SYNC_STAGES];
    logic [c_N_USED-1:0] w_synced;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= device_inputs[c_N_USED-1:0];
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    if (N_IN > c_N_USED) begin : g_unused_in
        logic w_unused_inputs;
        assign w_unused_inputs = ^device_inputs[N_IN-1:c_N_USED];
    end

    // ------------------------------------------------------------------
    // Button debouncers: state only follows the synced value once it has
    // differed for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    logic [2:0] w_btn_sync;
    logic [2:0] w_btn_deb;
    logic [2:0] r_btn_deb_d;

    assign w_btn_sync = {w_synced[c_BIT_WRITE], w_synced[c_BIT_RST], w_synced[c_BIT_STEP]};

    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_state;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt   <= '0;
                r_state <= 1'b0;
            end else if (w_btn_sync[gi] == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_state <= w_btn_sync[gi];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_btn_deb[gi] = r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_deb_d <= '0;
        end else begin
            r_btn_deb_d <= w_btn_deb;
        end
    end

    logic w_step_rise;
    logic w_write_rise;

    assign w_step_rise  = w_btn_deb[c_BTN_STEP]  & ~r_btn_deb_d[c_BTN_STEP];
    assign w_write_rise = w_btn_deb[c_BTN_WRITE] & ~r_btn_deb_d[c_BTN_WRITE];

    // ------------------------------------------------------------------
    // Clock step pulse; free-run mode masks manual stepping.
    // ------------------------------------------------------------------
    logic r_clk_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_step <= 1'b0;
        end else begin
            r_clk_step <= w_step_rise & ~w_synced[c_BIT_AUTO];
        end
    end

    // ------------------------------------------------------------------
    // Programming-write handshake. Capture happens only from idle, so a
    // write edge in the acceptance cycle is still counted as dropped.
    // ------------------------------------------------------------------
    logic              r_prog_valid;
    logic              r_prog_drop;
    logic [ADDR_W-1:0] r_prog_addr;
    logic [DATA_W-1:0] r_prog_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prog_valid <= 1'b0;
            r_prog_drop  <= 1'b0;
            r_prog_addr  <= '0;
            r_prog_data  <= '0;
        end else begin
            if (r_prog_valid && prog.prog_ready) begin
                r_prog_valid <= 1'b0;
            end
            if (w_write_rise && w_synced[c_BIT_PEN]) begin
                if (r_prog_valid) begin
                    r_prog_drop <= 1'b1;
                end else begin
                    r_prog_valid <= 1'b1;
                    r_prog_addr  <= w_synced[c_BIT_ADDR +: ADDR_W];
                    r_prog_data  <= w_synced[c_BIT_DATA +: DATA_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Debug snapshot, held while the freeze switch is on.
    // ------------------------------------------------------------------
    logic [N_OUT-1:0] r_dev_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dev_out <= '0;
        end else if (!w_synced[c_BIT_FREEZE]) begin
            r_dev_out <= dbg_vector;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign device_outputs          = r_dev_out;
    assign clk_auto_en             = w_synced[c_BIT_AUTO];
    assign programming_en          = w_synced[c_BIT_PEN];
    assign clk_step                = r_clk_step;
    assign cpu_reset               = w_btn_deb[c_BTN_RST];
    assign prog.prog_valid         = r_prog_valid;
    assign prog.ProgrammingAddress = r_prog_addr;
    assign prog.ProgrammingData    = r_prog_data;
    assign prog_drop               = r_prog_drop;

endmodule
`default_nettype wire
